// File: rtl/rmme_pkg.sv
// Shared constants and types for the RMME multiply/exponent-align pipeline.
package rmme_pkg;

    localparam int MW_DEF = 4;
    localparam int EW_DEF = 4;
    localparam int CW_DEF = 16;

    typedef enum logic {
        MODE_INT = 1'b0,
        MODE_FP  = 1'b1
    } mode_e;

endpackage

// File: rtl/rmme_if.sv
// Operand/result handshake bundle; master drives operands, slave returns results.
interface rmme_if
    import rmme_pkg::*;
#(
    parameter int MW = MW_DEF,
    parameter int EW = EW_DEF
);

    logic          in_valid;
    logic          in_ready;
    mode_e         mode;
    logic          a_sign;
    logic          b_sign;
    logic [EW-1:0] a_exp;
    logic [EW-1:0] b_exp;
    logic [MW-1:0] a_man;
    logic [MW-1:0] b_man;

    logic            out_valid;
    logic            out_ready;
    logic [2*MW-1:0] out_pp;
    logic            out_sign;
    logic [EW-1:0]   out_emax;
    logic [EW-1:0]   out_oe1;
    logic [EW-1:0]   out_oe2;
    logic            out_zero;

    modport master (
        output in_valid, mode, a_sign, b_sign, a_exp, b_exp, a_man, b_man, out_ready,
        input  in_ready, out_valid, out_pp, out_sign, out_emax, out_oe1, out_oe2, out_zero
    );

    modport slave (
        input  in_valid, mode, a_sign, b_sign, a_exp, b_exp, a_man, b_man, out_ready,
        output in_ready, out_valid, out_pp, out_sign, out_emax, out_oe1, out_oe2, out_zero
    );

endinterface

// File: rtl/rmme_core.sv
// Combinational mantissa multiply plus exponent compare/align-shift computation.
module rmme_core
    import rmme_pkg::*;
#(
    parameter int MW = MW_DEF,
    parameter int EW = EW_DEF
) (
    input  mode_e           mode,
    input  logic            a_sign,
    input  logic            b_sign,
    input  logic [EW-1:0]   a_exp,
    input  logic [EW-1:0]   b_exp,
    input  logic [MW-1:0]   a_man,
    input  logic [MW-1:0]   b_man,
    output logic [2*MW-1:0] pp,
    output logic            sign,
    output logic [EW-1:0]   emax,
    output logic [EW-1:0]   oe1,
    output logic [EW-1:0]   oe2,
    output logic            zero
);

    localparam int PW = 2 * MW;

    logic [EW-1:0] emax_fp;

    always_comb begin
        pp      = PW'(a_man) * PW'(b_man);
        zero    = (pp == '0);
        emax_fp = (a_exp >= b_exp) ? a_exp : b_exp;
        sign    = 1'b0;
        emax    = '0;
        oe1     = '0;
        oe2     = '0;
        // Integer mode ignores exponents and signs entirely.
        if (mode == MODE_FP) begin
            sign = a_sign ^ b_sign;
            emax = emax_fp;
            oe1  = emax_fp - a_exp;
            oe2  = emax_fp - b_exp;
        end
    end

endmodule

// File: rtl/rmme_pipe.sv
// Two-stage valid/ready pipeline around rmme_core with a saturating result counter.
module rmme_pipe
    import rmme_pkg::*;
#(
    parameter int MW = MW_DEF,
    parameter int EW = EW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    rmme_if.slave         bus,
    output logic [CW-1:0] op_count
);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic vld_p1, vld_p2;
    logic s2_open, s1_adv, in_rdy, in_xfer, out_xfer;

    mode_e         mode_p1;
    logic          a_sign_p1, b_sign_p1;
    logic [EW-1:0] a_exp_p1, b_exp_p1;
    logic [MW-1:0] a_man_p1, b_man_p1;

    logic [2*MW-1:0] pp_c, pp_p2;
    logic            sign_c, sign_p2, zero_c, zero_p2;
    logic [EW-1:0]   emax_c, emax_p2, oe1_c, oe1_p2, oe2_c, oe2_p2;

    // in_ready depends only on stage state and out_ready, never on in_valid.
    assign out_xfer = vld_p2 & bus.out_ready;
    assign s2_open  = ~vld_p2 | bus.out_ready;
    assign s1_adv   = vld_p1 & s2_open;
    assign in_rdy   = ~vld_p1 | s1_adv;
    assign in_xfer  = bus.in_valid & in_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            op_count <= '0;
        end else begin
            if (in_rdy)   vld_p1   <= bus.in_valid;
            if (s2_open)  vld_p2   <= vld_p1;
            if (out_xfer) op_count <= sat_inc(op_count);
        end
    end

    // Stage 1: operand capture
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            mode_p1   <= bus.mode;
            a_sign_p1 <= bus.a_sign;
            b_sign_p1 <= bus.b_sign;
            a_exp_p1  <= bus.a_exp;
            b_exp_p1  <= bus.b_exp;
            a_man_p1  <= bus.a_man;
            b_man_p1  <= bus.b_man;
        end
    end

    rmme_core #(.MW(MW), .EW(EW)) u_core (
        .mode   (mode_p1),
        .a_sign (a_sign_p1),
        .b_sign (b_sign_p1),
        .a_exp  (a_exp_p1),
        .b_exp  (b_exp_p1),
        .a_man  (a_man_p1),
        .b_man  (b_man_p1),
        .pp     (pp_c),
        .sign   (sign_c),
        .emax   (emax_c),
        .oe1    (oe1_c),
        .oe2    (oe2_c),
        .zero   (zero_c)
    );

    // Stage 2: result registers, loaded only with real data so a stalled result stays put
    always_ff @(posedge clk) begin
        if (rst) begin
            pp_p2   <= '0;
            sign_p2 <= 1'b0;
            emax_p2 <= '0;
            oe1_p2  <= '0;
            oe2_p2  <= '0;
            zero_p2 <= 1'b1;
        end else if (s1_adv) begin
            pp_p2   <= pp_c;
            sign_p2 <= sign_c;
            emax_p2 <= emax_c;
            oe1_p2  <= oe1_c;
            oe2_p2  <= oe2_c;
            zero_p2 <= zero_c;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = vld_p2;
    assign bus.out_pp    = pp_p2;
    assign bus.out_sign  = sign_p2;
    assign bus.out_emax  = emax_p2;
    assign bus.out_oe1   = oe1_p2;
    assign bus.out_oe2   = oe2_p2;
    assign bus.out_zero  = zero_p2;

endmodule

// File: tb/tb_rmme_pipe.sv
// Bench for rmme_pipe (MW=4, EW=4, CW=4): vector table, corner sequences, random stream vs model.
module tb_rmme_pipe;
    import rmme_pkg::*;

    typedef struct packed {
        logic       mode;
        logic       asg;
        logic [3:0] ae;
        logic [3:0] am;
        logic       bsg;
        logic [3:0] be;
        logic [3:0] bm;
    } op_t;

    typedef struct packed {
        logic [7:0] pp;
        logic       sg;
        logic [3:0] emax;
        logic [3:0] oe1;
        logic [3:0] oe2;
        logic       zero;
    } res_t;

    typedef struct {
        op_t  op;
        res_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] op_count;

    rmme_if #(.MW(4), .EW(4)) bus ();

    rmme_pipe #(.MW(4), .EW(4), .CW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   out_seen = 0;
    int   mcnt = 0;
    res_t sbq[$];
    res_t cur_res;
    op_t  cur_op;

    assign cur_res = {bus.out_pp, bus.out_sign, bus.out_emax, bus.out_oe1, bus.out_oe2, bus.out_zero};
    assign cur_op  = {bus.mode == MODE_FP, bus.a_sign, bus.a_exp, bus.a_man, bus.b_sign, bus.b_exp, bus.b_man};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: full product, max exponent and distances, sign xor; all exponent/sign fields zero for integers.
    function automatic res_t model(input op_t o);
        res_t r;
        int   p;
        int   hi;
        p  = int'(o.am) * int'(o.bm);
        hi = (int'(o.ae) > int'(o.be)) ? int'(o.ae) : int'(o.be);
        r.pp   = p[7:0];
        r.zero = (p == 0);
        if (o.mode) begin
            r.sg   = o.asg ^ o.bsg;
            r.emax = hi[3:0];
            r.oe1  = 4'(hi - int'(o.ae));
            r.oe2  = 4'(hi - int'(o.be));
        end else begin
            r.sg   = 1'b0;
            r.emax = 4'd0;
            r.oe1  = 4'd0;
            r.oe2  = 4'd0;
        end
        return r;
    endfunction

    function automatic op_t rand_op();
        logic [31:0] r;
        r = $urandom;
        return r[18:0];
    endfunction

    task automatic drive(input op_t o);
        bus.mode   = o.mode ? MODE_FP : MODE_INT;
        bus.a_sign = o.asg;
        bus.a_exp  = o.ae;
        bus.a_man  = o.am;
        bus.b_sign = o.bsg;
        bus.b_exp  = o.be;
        bus.b_man  = o.bm;
    endtask

    task automatic drain(input int budget);
        int done;
        done = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #2;
            if (sbq.size() == 0 && !bus.out_valid) begin
                done = 1;
                break;
            end
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    // Scoreboard: transfers seen at negedge take effect at the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            mcnt = 0;
        end else begin
            check("op_count", 32'(op_count), 32'(mcnt));
            if (bus.out_valid) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got out_pp=%0h, expected no output", bus.out_pp);
                end else begin
                    check("sb_result", 32'(cur_res), 32'(sbq[0]));
                    if (bus.out_ready) void'(sbq.pop_front());
                end
                if (bus.out_ready) begin
                    out_seen++;
                    mcnt = (mcnt >= 15) ? 15 : mcnt + 1;
                end
            end
            if (bus.in_valid && bus.in_ready) sbq.push_back(model(cur_op));
        end
    end

    vec_t tbl[8];
    int   lat, got, acc, seen0;
    res_t snap;

    initial begin
        tbl[0] = '{'{1'b1, 1'b0, 4'd3, 4'hF, 1'b1, 4'd7, 4'hF}, '{8'hE1, 1'b1, 4'd7, 4'd4, 4'd0, 1'b0}};
        tbl[1] = '{'{1'b0, 1'b0, 4'd9, 4'h3, 1'b0, 4'd0, 4'h2}, '{8'h06, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0}};
        tbl[2] = '{'{1'b1, 1'b0, 4'd5, 4'h0, 1'b0, 4'd5, 4'hA}, '{8'h00, 1'b0, 4'd5, 4'd0, 4'd0, 1'b1}};
        tbl[3] = '{'{1'b1, 1'b1, 4'hC, 4'h7, 1'b1, 4'h2, 4'h9}, '{8'h3F, 1'b0, 4'hC, 4'd0, 4'hA, 1'b0}};
        tbl[4] = '{'{1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 4'h1, 4'hF}, '{8'hE1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0}};
        tbl[5] = '{'{1'b1, 1'b1, 4'hF, 4'h8, 1'b0, 4'h0, 4'h1}, '{8'h08, 1'b1, 4'hF, 4'd0, 4'hF, 1'b0}};
        tbl[6] = '{'{1'b0, 1'b1, 4'h3, 4'hC, 1'b0, 4'h4, 4'h0}, '{8'h00, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1}};
        tbl[7] = '{'{1'b1, 1'b0, 4'h0, 4'h5, 1'b0, 4'h0, 4'h5}, '{8'h19, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0}};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive('0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_pp", 32'(bus.out_pp), 32'd0);
        check("rst_out_zero", 32'(bus.out_zero), 32'd1);
        check("rst_fields", 32'({bus.out_sign, bus.out_emax, bus.out_oe1, bus.out_oe2}), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single operations with exact expected results and latency
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].op);
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            lat = 0;
            got = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                lat++;
                if (bus.out_valid) begin
                    got = 1;
                    break;
                end
            end
            check("tbl_got_output", 32'(got), 32'd1);
            check("tbl_latency", 32'(lat), 32'd2);
            check("tbl_result", 32'(cur_res), 32'(tbl[i].exp));
            @(posedge clk);
            #1;
        end

        // Backpressure: two accepts fill the pipe, then a stalled result must hold
        bus.out_ready = 1'b0;
        acc = 0;
        drive(rand_op());
        bus.in_valid = 1'b1;
        for (int k = 0; k < 20 && acc < 2; k++) begin
            @(negedge clk);
            got = int'(bus.in_ready);
            @(posedge clk);
            #1;
            if (got == 1) begin
                acc++;
                drive(rand_op());
            end
        end
        @(negedge clk);
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        snap = cur_res;
        seen0 = out_seen;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_stable", 32'(cur_res), 32'(snap));
            check("bp_in_ready_held", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && acc < 3; k++) begin
            @(negedge clk);
            got = int'(bus.in_ready);
            @(posedge clk);
            #1;
            if (got == 1) acc++;
        end
        bus.in_valid = 1'b0;
        check("bp_accepts", 32'(acc), 32'd3);
        drain(20);
        check("bp_outputs", 32'(out_seen - seen0), 32'd3);

        // Random mixed-mode stream with random backpressure
        for (int c = 0; c < 300; c++) begin
            drive(rand_op());
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain(50);

        // Reset with both stages full discards both results
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        acc = 0;
        drive(rand_op());
        bus.in_valid = 1'b1;
        for (int k = 0; k < 20 && acc < 2; k++) begin
            @(negedge clk);
            got = int'(bus.in_ready);
            @(posedge clk);
            #1;
            if (got == 1) acc++;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        seen0 = out_seen;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("mr_out_valid", 32'(bus.out_valid), 32'd0);
        check("mr_op_count", 32'(op_count), 32'd0);
        check("mr_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (5) @(posedge clk);
        #2;
        check("mr_no_outputs", 32'(out_seen - seen0), 32'd0);

        // Counter saturation after 20 consumed results
        acc = 0;
        drive(rand_op());
        bus.in_valid = 1'b1;
        for (int k = 0; k < 100 && acc < 20; k++) begin
            @(negedge clk);
            got = int'(bus.in_ready);
            @(posedge clk);
            #1;
            if (got == 1) begin
                acc++;
                drive(rand_op());
            end
        end
        bus.in_valid = 1'b0;
        drain(20);
        check("sat_count", 32'(op_count), 32'd15);
        repeat (3) @(posedge clk);
        #2;
        check("sat_held", 32'(op_count), 32'd15);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
